interconnect_sequencer: RTL and testbench

Control-side counterpart of the Interconnections datapath. It accepts a command (function code plus source select) over a valid/ready handshake and loads two operands serially from an 8-bit operand bus. It then drives Aside/Bside/select_source/Function into the datapath, waits a settle period, samples Outbus, and returns the result over a valid/ready handshake. It sits between the command/operand producer and the combinational Interconnections block.

---
 rtl/interconnect_sequencer.sv | 124 ++++++++++++
 tb/tb_interconnect_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interconnect_sequencer.sv
// Sequencer that feeds the combinational Interconnections datapath: it takes a command,
// loads operands A and B serially, waits for Outbus to settle and returns the captured result.
module interconnect_sequencer #(
   parameter int DATA_W        = 8,
   parameter int COUNT_W       = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_func,
   input  logic               cmd_src,
   input  logic               opnd_valid,
   input  logic [DATA_W-1:0]  opnd_data,
   output logic [DATA_W-1:0]  Aside,
   output logic [DATA_W-1:0]  Bside,
   output logic               select_source,
   output logic [1:0]         Function,
   input  logic [DATA_W-1:0]  Outbus,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_data,
   output logic               busy,
   output logic [COUNT_W-1:0] op_count
);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                src_q, src_d;
   logic [1:0]          func_q, func_d;
   logic [3:0]          settle_q, settle_d;
   logic [COUNT_W-1:0]  count_q, count_d;

   // Handshake: a transfer happens on any rising edge where valid and ready are both high;
   // the operand bus has no ready and is consumed only while waiting for A or B.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      src_d    = src_q;
      func_d   = func_q;
      settle_d = settle_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               func_d  = cmd_func;
               src_d   = cmd_src;
               state_d = LOAD_A;
            end
         end
         LOAD_A: begin
            if (opnd_valid) begin
               a_d     = opnd_data;
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (opnd_valid) begin
               b_d      = opnd_data;
               settle_d = '0;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            // Datapath inputs have been stable for SETTLE_CYCLES edges when Outbus is taken.
            if (settle_q == SETTLE_LAST) begin
               res_d   = Outbus;
               state_d = DONE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         DONE: begin
            if (res_ready) begin
               count_d = count_q + COUNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         src_q    <= 1'b0;
         func_q   <= 2'd0;
         settle_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         src_q    <= src_d;
         func_q   <= func_d;
         settle_q <= settle_d;
         count_q  <= count_d;
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign res_valid     = (state_q == DONE);
   assign Aside         = a_q;
   assign Bside         = b_q;
   assign select_source = src_q;
   assign Function      = func_q;
   assign res_data      = res_q;
   assign op_count      = count_q;

endmodule

// File: tb/tb_interconnect_sequencer.sv
// Bench for interconnect_sequencer: one instance with the default settle time and a stub
// Outbus = Aside + Bside, a second with a four-cycle settle time and a scripted Outbus.
module tb_interconnect_sequencer;
   localparam int DW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_func = 2'd0;
   logic          cmd_src = 1'b0;
   logic          opnd_valid = 1'b0;
   logic [DW-1:0] opnd_data = '0;
   logic          res_ready = 1'b0;

   logic          cmd_ready1, sel1, res_valid1, busy1;
   logic [1:0]    func1;
   logic [DW-1:0] aside1, bside1, outbus1, res_data1;
   logic [CW-1:0] op_count1;

   logic          cmd_ready4, sel4, res_valid4, busy4;
   logic [1:0]    func4;
   logic [DW-1:0] aside4, bside4, res_data4;
   logic [DW-1:0] outbus4 = '0;
   logic [CW-1:0] op_count4;

   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   logic [CW-1:0] exp_count = '0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign outbus1 = aside1 + bside1;

   interconnect_sequencer #(.DATA_W(DW), .COUNT_W(CW), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
      .cmd_func(cmd_func), .cmd_src(cmd_src), .opnd_valid(opnd_valid), .opnd_data(opnd_data),
      .Aside(aside1), .Bside(bside1), .select_source(sel1), .Function(func1),
      .Outbus(outbus1), .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
      .busy(busy1), .op_count(op_count1)
   );

   interconnect_sequencer #(.DATA_W(DW), .COUNT_W(CW), .SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
      .cmd_func(cmd_func), .cmd_src(cmd_src), .opnd_valid(opnd_valid), .opnd_data(opnd_data),
      .Aside(aside4), .Bside(bside4), .select_source(sel4), .Function(func4),
      .Outbus(outbus4), .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4),
      .busy(busy4), .op_count(op_count4)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_count = '0;
   endtask

   task automatic send_cmd(input logic [1:0] f, input logic s);
      cmd_func  = f;
      cmd_src   = s;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmd_func  = 2'($urandom_range(0, 3));
      cmd_src   = 1'($urandom_range(0, 1));
   endtask

   task automatic send_opnd(input logic [DW-1:0] d, input int gap);
      opnd_valid = 1'b0;
      repeat (gap) step();
      opnd_valid = 1'b1;
      opnd_data  = d;
      step();
      opnd_valid = 1'b0;
      opnd_data  = DW'($urandom_range(0, 255));
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (res_valid1 !== 1'b1 && n < 64) begin
         step();
         n++;
      end
   endtask

   task automatic release_res();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (cmd_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%0d exp=1", cmd_ready1); end
      n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0d exp=0", busy1); end
      n_checks++; if (res_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%0d exp=0", res_valid1); end
      n_checks++; if ({aside1, bside1, res_data1} !== '0) begin n_fail++; $display("FAIL reset_data got=%0d/%0d/%0d exp=0", aside1, bside1, res_data1); end
      n_checks++; if ({sel1, func1} !== 3'd0) begin n_fail++; $display("FAIL reset_sel_func got=%0d/%0d exp=0", sel1, func1); end
      n_checks++; if (op_count1 !== '0) begin n_fail++; $display("FAIL reset_op_count got=%0d exp=0", op_count1); end
   endtask

   task automatic test_basic();
      int n, e0;
      send_cmd(2'd0, 1'b0);
      e0 = cyc;
      n_checks++; if (cmd_ready1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_load_a_flags got=%0d/%0d exp=0/1", cmd_ready1, busy1); end
      send_opnd(8'd5, 0);
      n_checks++; if (aside1 !== 8'd5) begin n_fail++; $display("FAIL basic_aside got=%0d exp=5", aside1); end
      send_opnd(8'd20, 0);
      n_checks++; if (bside1 !== 8'd20) begin n_fail++; $display("FAIL basic_bside got=%0d exp=20", bside1); end
      wait_res(n);
      n_checks++; if (cyc - e0 !== 3) begin n_fail++; $display("FAIL basic_latency got=%0d exp=3", cyc - e0); end
      n_checks++; if (res_data1 !== 8'd25) begin n_fail++; $display("FAIL basic_res_data got=%0d exp=25", res_data1); end
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (res_valid1 !== 1'b1 || res_data1 !== 8'd25 || cmd_ready1 !== 1'b0 || op_count1 !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_hold[%0d] got valid=%0d data=%0d ready=%0d count=%0d exp 1/25/0/0", i, res_valid1, res_data1, cmd_ready1, op_count1);
         end
      end
      release_res();
      exp_count++;
      n_checks++; if (op_count1 !== exp_count || res_valid1 !== 1'b0) begin n_fail++; $display("FAIL basic_complete got count=%0d valid=%0d exp=%0d/0", op_count1, res_valid1, exp_count); end
   endtask

   task automatic test_func_sweep();
      int n;
      do_reset();
      for (int f = 0; f < 4; f++) begin
         send_cmd(2'(f), 1'b1);
         n_checks++; if (func1 !== 2'(f) || sel1 !== 1'b1) begin n_fail++; $display("FAIL sweep_func[%0d] got func=%0d src=%0d exp=%0d/1", f, func1, sel1, f); end
         send_opnd(8'd56, 0);
         send_opnd(8'd5, 0);
         wait_res(n);
         n_checks++; if (n !== 1 || res_data1 !== 8'd61) begin n_fail++; $display("FAIL sweep_res[%0d] got wait=%0d data=%0d exp=1/61", f, n, res_data1); end
         n_checks++; if (func1 !== 2'(f) || sel1 !== 1'b1) begin n_fail++; $display("FAIL sweep_hold[%0d] got func=%0d src=%0d exp=%0d/1", f, func1, sel1, f); end
         release_res();
         exp_count++;
      end
      n_checks++; if (op_count1 !== 8'd4) begin n_fail++; $display("FAIL sweep_op_count got=%0d exp=4", op_count1); end
   endtask

   task automatic test_operand_gap();
      int n, e0;
      opnd_valid = 1'b1;
      opnd_data  = 8'd77;
      step();
      opnd_valid = 1'b0;
      n_checks++; if (busy1 !== 1'b0 || aside1 !== 8'd56) begin n_fail++; $display("FAIL gap_idle_pulse got busy=%0d aside=%0d exp=0/56", busy1, aside1); end
      send_cmd(2'd2, 1'b0);
      e0 = cyc;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (busy1 !== 1'b1 || aside1 !== 8'd56) begin n_fail++; $display("FAIL gap_a[%0d] got busy=%0d aside=%0d exp=1/56", i, busy1, aside1); end
      end
      send_opnd(8'd9, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (busy1 !== 1'b1 || bside1 !== 8'd5 || res_valid1 !== 1'b0) begin n_fail++; $display("FAIL gap_b[%0d] got busy=%0d bside=%0d valid=%0d exp=1/5/0", i, busy1, bside1, res_valid1); end
      end
      send_opnd(8'd13, 0);
      wait_res(n);
      n_checks++; if (cyc - e0 !== 8) begin n_fail++; $display("FAIL gap_latency got=%0d exp=8", cyc - e0); end
      n_checks++; if (res_data1 !== 8'd22) begin n_fail++; $display("FAIL gap_res_data got=%0d exp=22", res_data1); end
      release_res();
      exp_count++;
   endtask

   task automatic test_settle();
      int e0;
      do_reset();
      outbus4 = 8'd0;
      send_cmd(2'd1, 1'b0);
      e0 = cyc;
      send_opnd(8'd3, 0);
      send_opnd(8'd4, 0);
      repeat (3) step();
      n_checks++; if (res_valid4 !== 1'b0 || busy4 !== 1'b1) begin n_fail++; $display("FAIL settle_early got valid=%0d busy=%0d exp=0/1", res_valid4, busy4); end
      outbus4 = 8'd99;
      step();
      n_checks++; if (res_valid4 !== 1'b1 || cyc - e0 !== 6) begin n_fail++; $display("FAIL settle_latency got valid=%0d edges=%0d exp=1/6", res_valid4, cyc - e0); end
      n_checks++; if (res_data4 !== 8'd99) begin n_fail++; $display("FAIL settle_res_data got=%0d exp=99", res_data4); end
      release_res();
      n_checks++; if (op_count4 !== 8'd1 || cmd_ready4 !== 1'b1) begin n_fail++; $display("FAIL settle_complete got count=%0d ready=%0d exp=1/1", op_count4, cmd_ready4); end
   endtask

   task automatic test_random();
      logic [1:0]    f;
      logic          s;
      logic [DW-1:0] a, b, exp;
      int            ga, gb, rd, n;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         f  = 2'($urandom_range(0, 3));
         s  = 1'($urandom_range(0, 1));
         a  = DW'($urandom_range(0, 255));
         b  = DW'($urandom_range(0, 255));
         ga = $urandom_range(0, 3);
         gb = $urandom_range(0, 3);
         rd = $urandom_range(0, 3);
         exp_q.push_back(DW'((int'(a) + int'(b)) % 256));
         send_cmd(f, s);
         send_opnd(a, ga);
         send_opnd(b, gb);
         wait_res(n);
         exp = exp_q.pop_front();
         n_checks++; if (n !== 1) begin n_fail++; $display("FAIL rand_wait[%0d] got=%0d exp=1", i, n); end
         n_checks++; if (res_data1 !== exp) begin n_fail++; $display("FAIL rand_res[%0d] got=%0d exp=%0d", i, res_data1, exp); end
         n_checks++; if (aside1 !== a || bside1 !== b || func1 !== f || sel1 !== s) begin n_fail++; $display("FAIL rand_regs[%0d] got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", i, aside1, bside1, func1, sel1, a, b, f, s); end
         cmd_valid = 1'b1;
         for (int k = 0; k < rd; k++) begin
            step();
            n_checks++; if (res_valid1 !== 1'b1 || op_count1 !== exp_count) begin n_fail++; $display("FAIL rand_hold[%0d] got valid=%0d count=%0d exp=1/%0d", i, res_valid1, op_count1, exp_count); end
         end
         release_res();
         cmd_valid = 1'b0;
         exp_count++;
         n_checks++; if (cmd_ready1 !== 1'b1 || op_count1 !== exp_count) begin n_fail++; $display("FAIL rand_done[%0d] got ready=%0d count=%0d exp=1/%0d", i, cmd_ready1, op_count1, exp_count); end
      end
   endtask

   task automatic test_reset_mid();
      send_cmd(2'd3, 1'b1);
      send_opnd(8'hAA, 0);
      send_opnd(8'h55, 0);
      n_checks++; if (busy1 !== 1'b1 || res_valid1 !== 1'b0) begin n_fail++; $display("FAIL mid_exec got busy=%0d valid=%0d exp=1/0", busy1, res_valid1); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++; if (cmd_ready1 !== 1'b1 || busy1 !== 1'b0 || res_valid1 !== 1'b0) begin n_fail++; $display("FAIL mid_flags got ready=%0d busy=%0d valid=%0d exp=1/0/0", cmd_ready1, busy1, res_valid1); end
      n_checks++; if ({aside1, bside1, res_data1, sel1, func1} !== '0) begin n_fail++; $display("FAIL mid_regs got %0d/%0d/%0d/%0d/%0d exp=0", aside1, bside1, res_data1, sel1, func1); end
      n_checks++; if (op_count1 !== '0) begin n_fail++; $display("FAIL mid_op_count got=%0d exp=0", op_count1); end
      step();
      n_checks++; if (res_valid1 !== 1'b0 || op_count1 !== '0) begin n_fail++; $display("FAIL mid_discard got valid=%0d count=%0d exp=0/0", res_valid1, op_count1); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      test_reset();
      test_basic();
      test_func_sweep();
      test_operand_gap();
      test_settle();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
